// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit saturating counters indexed by pc[TABLE_BITS+1:2], one-cycle registered prediction.
// Optional statistics counters are enabled by defining BRANCH_PREDICTOR_STATS_EN.
module branch_predictor #(
    parameter int PC_W       = 64,
    parameter int TABLE_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  flush,
    input  logic [PC_W-1:0]       fetch_pc,
    input  logic [6:0]            fetch_opcode,
    input  logic                  upd_valid,
    input  logic [PC_W-1:0]       upd_pc,
    input  logic                  upd_taken,
    input  logic                  upd_pred,
    output logic                  pred_taken,
    output logic [TABLE_BITS-1:0] pred_index
`ifdef BRANCH_PREDICTOR_STATS_EN
    ,
    output logic [31:0]           stat_branches,
    output logic [31:0]           stat_mispredicts
`endif
);
    localparam int         ENTRIES   = 1 << TABLE_BITS;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [1:0] CTR_RESET = 2'b01;

    function automatic logic [1:0] sat_counter(input logic [1:0] ctr, input logic taken);
        if (taken)
            return (ctr == 2'b11) ? ctr : ctr + 2'd1;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'd1;
    endfunction

    logic [1:0]            r_table [ENTRIES];
    logic [TABLE_BITS-1:0] w_fetch_idx;
    logic [TABLE_BITS-1:0] w_upd_idx;
    logic [1:0]            w_upd_ctr;
    logic [1:0]            w_lookup_ctr;
    logic                  w_pred_taken;
    logic                  r_pred_taken_p1;
    logic [TABLE_BITS-1:0] r_pred_index_p1;

    assign w_fetch_idx = fetch_pc[TABLE_BITS+1:2];
    assign w_upd_idx   = upd_pc[TABLE_BITS+1:2];
    assign w_upd_ctr   = sat_counter(r_table[w_upd_idx], upd_taken);

    // A same-cycle update to the looked-up entry is forwarded so the lookup sees the post-update counter.
    assign w_lookup_ctr = (upd_valid && (w_upd_idx == w_fetch_idx)) ? w_upd_ctr : r_table[w_fetch_idx];
    assign w_pred_taken = (fetch_opcode == OP_BRANCH) && w_lookup_ctr[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                r_table[i] <= CTR_RESET;
        end else if (upd_valid) begin
            r_table[w_upd_idx] <= w_upd_ctr;
        end
    end

    // Stage p1: IF/ID-aligned prediction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pred_taken_p1 <= 1'b0;
            r_pred_index_p1 <= '0;
        end else if (flush) begin
            r_pred_taken_p1 <= 1'b0;
            r_pred_index_p1 <= '0;
        end else if (enable) begin
            r_pred_taken_p1 <= w_pred_taken;
            r_pred_index_p1 <= w_fetch_idx;
        end
    end

    assign pred_taken = r_pred_taken_p1;
    assign pred_index = r_pred_index_p1;

`ifdef BRANCH_PREDICTOR_STATS_EN
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0] r_stat_branches;
    logic [31:0] r_stat_mispredicts;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else if (upd_valid) begin
            r_stat_branches <= sat_inc32(r_stat_branches);
            if (upd_taken != upd_pred)
                r_stat_mispredicts <= sat_inc32(r_stat_mispredicts);
        end
    end

    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;

    logic w_unused;
    assign w_unused = ^{fetch_pc[PC_W-1:TABLE_BITS+2], fetch_pc[1:0],
                        upd_pc[PC_W-1:TABLE_BITS+2], upd_pc[1:0]};
`else
    logic w_unused;
    assign w_unused = ^{fetch_pc[PC_W-1:TABLE_BITS+2], fetch_pc[1:0],
                        upd_pc[PC_W-1:TABLE_BITS+2], upd_pc[1:0], upd_pred};
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: directed vector table, hand sequences and a randomized run against a counter-array model.
module tb_branch_predictor;
    localparam int PC_W       = 64;
    localparam int TABLE_BITS = 6;
    localparam int ENTRIES    = 1 << TABLE_BITS;
    localparam logic [6:0] BR = 7'b1100011;
    localparam logic [6:0] NB = 7'b0010011;

    logic                  clk = 1'b0;
    logic                  rst, enable, flush;
    logic [PC_W-1:0]       fetch_pc, upd_pc;
    logic [6:0]            fetch_opcode;
    logic                  upd_valid, upd_taken, upd_pred;
    logic                  pred_taken;
    logic [TABLE_BITS-1:0] pred_index;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0]           stat_branches, stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor #(.PC_W(PC_W), .TABLE_BITS(TABLE_BITS)) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .fetch_pc(fetch_pc), .fetch_opcode(fetch_opcode),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_pred(upd_pred),
        .pred_taken(pred_taken), .pred_index(pred_index)
`ifdef BRANCH_PREDICTOR_STATS_EN
        , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
    );

    typedef struct {
        logic            rst, en, fl;
        logic [PC_W-1:0] pc;
        logic [6:0]      op;
        logic            uv;
        logic [PC_W-1:0] upc;
        logic            ut;
        logic            exp_t;
        int              exp_i;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   model[ENTRIES];

    function automatic vec_t mk(input logic r, input logic e, input logic f, input logic [PC_W-1:0] pc,
                                input logic [6:0] op, input logic uv, input logic [PC_W-1:0] upc,
                                input logic ut, input logic et, input int ei);
        vec_t v;
        v.rst = r; v.en = e; v.fl = f; v.pc = pc; v.op = op;
        v.uv = uv; v.upc = upc; v.ut = ut; v.exp_t = et; v.exp_i = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic [PC_W-1:0] pc,
                         input logic [6:0] op, input logic uv, input logic [PC_W-1:0] upc,
                         input logic ut, input logic up);
        rst = r; enable = e; flush = f; fetch_pc = pc; fetch_opcode = op;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_pred = up;
    endtask

    int   exp_t, exp_i, idx, uidx;
    logic r_rst, r_en, r_fl, r_uv, r_ut;
    logic [6:0] r_op;
    logic [PC_W-1:0] r_pc, r_upc;

    initial begin
        drive(1, 1, 0, '0, NB, 0, '0, 0, 0);

        // rows: rst en fl fetch_pc op upd_valid upd_pc upd_taken | expected taken, index
        vecs.push_back(mk(1, 1, 0, 64'h104, BR, 1, 64'h100, 1, 0, 0));  // reset discards update
        vecs.push_back(mk(0, 1, 0, 64'h100, BR, 0, 64'h0,   0, 0, 0));  // reset value 01
        vecs.push_back(mk(0, 1, 0, 64'h0,   NB, 1, 64'h100, 1, 0, 0));  // ->10
        vecs.push_back(mk(0, 1, 0, 64'h0,   NB, 1, 64'h100, 1, 0, 0));  // ->11
        vecs.push_back(mk(0, 1, 0, 64'h100, BR, 0, 64'h0,   0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 64'h200, BR, 1, 64'h100, 1, 1, 0));  // saturate 11, alias 0x200
        vecs.push_back(mk(0, 1, 0, 64'h100, BR, 1, 64'h100, 0, 1, 0));  // ->10 bypass
        vecs.push_back(mk(0, 1, 0, 64'h100, BR, 1, 64'h100, 0, 0, 0));  // ->01 bypass
        vecs.push_back(mk(0, 1, 0, 64'h104, BR, 1, 64'h104, 1, 1, 1));  // idx1 01->10 bypass
        vecs.push_back(mk(0, 0, 0, 64'h0,   NB, 0, 64'h0,   0, 1, 1));  // stall holds
        vecs.push_back(mk(0, 0, 1, 64'h104, BR, 0, 64'h0,   0, 0, 0));  // flush beats stall
        vecs.push_back(mk(0, 1, 0, 64'h104, NB, 0, 64'h0,   0, 0, 1));  // non-branch at taken PC
        vecs.push_back(mk(0, 0, 0, 64'h104, BR, 1, 64'h104, 1, 0, 1));  // update during stall ->11
        vecs.push_back(mk(0, 1, 1, 64'h104, BR, 0, 64'h0,   0, 0, 0));  // flush beats load
        vecs.push_back(mk(0, 1, 0, 64'h104, BR, 0, 64'h0,   0, 1, 1));
        vecs.push_back(mk(1, 1, 1, 64'h104, BR, 1, 64'h104, 1, 0, 0));  // reset over all
        vecs.push_back(mk(0, 1, 0, 64'h104, BR, 0, 64'h0,   0, 0, 1));  // table back to 01
        vecs.push_back(mk(0, 1, 0, 64'h100, BR, 1, 64'h100, 0, 0, 0));  // ->00
        vecs.push_back(mk(0, 1, 0, 64'h0,   NB, 1, 64'h100, 0, 0, 0));  // stays 00
        vecs.push_back(mk(0, 1, 0, 64'h0,   NB, 1, 64'h100, 1, 0, 0));  // ->01
        vecs.push_back(mk(0, 1, 0, 64'h100, BR, 0, 64'h0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 64'h1FC, BR, 0, 64'h0,   0, 0, 63)); // top index

        foreach (vecs[k]) begin
            @(negedge clk);
            drive(vecs[k].rst, vecs[k].en, vecs[k].fl, vecs[k].pc, vecs[k].op,
                  vecs[k].uv, vecs[k].upc, vecs[k].ut, 1'b0);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d pred_taken", k), {63'd0, pred_taken}, {63'd0, vecs[k].exp_t});
            check($sformatf("vec%0d pred_index", k), {58'd0, pred_index}, 64'(vecs[k].exp_i));
        end

`ifdef BRANCH_PREDICTOR_STATS_EN
        @(negedge clk); drive(1, 1, 0, '0, NB, 0, '0, 0, 0);
        @(negedge clk); drive(0, 1, 0, '0, NB, 1, 64'h100, 1, 0);
        @(negedge clk); drive(0, 1, 0, '0, NB, 1, 64'h100, 1, 1);
        @(negedge clk); drive(0, 1, 0, '0, NB, 1, 64'h100, 0, 1);
        @(negedge clk); drive(0, 1, 0, '0, NB, 0, '0, 0, 0);
        #1;
        check("stat_branches", 64'(stat_branches), 64'd3);
        check("stat_mispredicts", 64'(stat_mispredicts), 64'd2);
        drive(1, 1, 0, '0, NB, 1, 64'h100, 1, 0);
        @(posedge clk); #1;
        check("stat_branches_rst", 64'(stat_branches), 64'd0);
        check("stat_mispredicts_rst", 64'(stat_mispredicts), 64'd0);
`endif

        exp_t = 0;
        exp_i = 0;
        for (int c = 0; c < 600; c++) begin
            r_rst = (c == 0) || ($urandom_range(0, 99) < 2);
            r_en  = $urandom_range(0, 99) < 80;
            r_fl  = $urandom_range(0, 99) < 8;
            r_op  = ($urandom_range(0, 99) < 70) ? BR : 7'($urandom);
            r_pc  = {$urandom, $urandom_range(0, 15), 2'($urandom)};
            r_pc  = {r_pc[PC_W-1:8], 8'($urandom_range(0, 15) << 2)} | 64'($urandom_range(0, 3));
            r_uv  = $urandom_range(0, 99) < 60;
            r_upc = {$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FF3F;
            r_upc = (r_upc & ~64'h3C) | 64'($urandom_range(0, 15) << 2);
            r_ut  = $urandom_range(0, 1) == 1;
            @(negedge clk);
            drive(r_rst, r_en, r_fl, r_pc, r_op, r_uv, r_upc, r_ut, 1'($urandom));
            if (r_rst) begin
                foreach (model[m]) model[m] = 1;
                exp_t = 0;
                exp_i = 0;
            end else begin
                if (r_uv) begin
                    uidx = int'((r_upc >> 2) % ENTRIES);
                    model[uidx] = r_ut ? ((model[uidx] < 3) ? model[uidx] + 1 : 3)
                                       : ((model[uidx] > 0) ? model[uidx] - 1 : 0);
                end
                idx = int'((r_pc >> 2) % ENTRIES);
                if (r_fl) begin
                    exp_t = 0;
                    exp_i = 0;
                end else if (r_en) begin
                    exp_t = ((r_op == BR) && (model[idx] >= 2)) ? 1 : 0;
                    exp_i = idx;
                end
            end
            @(posedge clk);
            #1;
            check($sformatf("rand%0d pred_taken", c), {63'd0, pred_taken}, 64'(exp_t));
            check($sformatf("rand%0d pred_index", c), {58'd0, pred_index}, 64'(exp_i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
- REQ-001 Parameter PC_W, default 64: width of the program-counter inputs.
- REQ-002 Parameter TABLE_BITS, default 6: log2 of the number of counter-table entries (64 entries).
- REQ-003 clk  input  1  single clock; all state updates on the rising edge.
- REQ-004 rst  input  1  reset, synchronous and active-high.
- REQ-005 enable  input  1  IF/ID advance; 0 = stall, hold the prediction output.
- REQ-006 flush  input  1  IF/ID flush from the control unit; forces a bubble prediction.
- REQ-007 fetch_pc  input  PC_W  PC of the instruction currently being fetched.
- REQ-008 fetch_opcode  input  7  opcode[6:0] of the fetched instruction.
- REQ-009 upd_valid  input  1  a conditional branch resolved in ID this cycle.
- REQ-010 upd_pc  input  PC_W  PC of the resolved branch.
- REQ-011 upd_taken  input  1  actual outcome (1 = taken).
- REQ-012 upd_pred  input  1  prediction that was made for that branch.
- REQ-013 pred_taken  output  1  registered prediction, aligned with the IF/ID instruction; drives the control unit's branchTaken.
- REQ-014 pred_index  output  TABLE_BITS  registered table index used for pred_taken.

Function
- REQ-015 The table SHALL hold 2^TABLE_BITS two-bit saturating counters with encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T; a counter predicts taken when bit 1 = 1.
- REQ-016 The index SHALL be pc[TABLE_BITS+1:2] for both lookup and update; aliasing between PCs is permitted and is not detected.
- REQ-017 Lookup SHALL be combinational from fetch_pc; pred_taken/pred_index SHALL be registered, i.e. one-cycle latency to align with IF/ID.
- REQ-018 When fetch_opcode != 7'b1100011 (BRANCH), the registered pred_taken SHALL be 0; pred_index SHALL still register the computed index.
- REQ-019 With upd_valid=1, the counter at the update index SHALL increment on upd_taken=1 (saturating at 11) and decrement on upd_taken=0 (saturating at 00).
- REQ-020 Updates SHALL be applied regardless of enable and flush.
- REQ-021 When an update and a BRANCH lookup hit the same index in the same cycle, the lookup SHALL use the post-update counter value (bypass).
- REQ-022 Output register priority SHALL be: rst > flush (pred_taken<=0, pred_index<=0) > enable=0 (hold) > load.
- REQ-023 upd_pred SHALL affect only the statistics counters (REQ-027); it SHALL NOT affect the table.

Reset
- REQ-024 On rst, every table entry SHALL become 01 in one cycle, and pred_taken and pred_index SHALL become 0.
- REQ-025 Reset SHALL override any concurrent update, flush or lookup; an update presented in the reset cycle is discarded.
- REQ-026 After rst deasserts, the first lookup SHALL observe reset table values.

Configuration
- REQ-027 With macro BRANCH_PREDICTOR_STATS_EN defined, the block SHALL add outputs stat_branches[31:0] (+1 per upd_valid) and stat_mispredicts[31:0] (+1 per upd_valid with upd_taken != upd_pred); both counters SHALL saturate at 32'hFFFF_FFFF and clear on rst.
- REQ-028 Without BRANCH_PREDICTOR_STATS_EN, these ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
- REQ-029 Reset, then fetch BRANCH at fetch_pc=0x100 -> next cycle pred_taken=0, pred_index=0.
- REQ-030 Two updates taken at upd_pc=0x100, then fetch 0x100 -> pred_taken=1; one further taken update leaves the counter at 11; two not-taken updates -> counter 01, pred_taken=0.
- REQ-031 Aliasing: train 0x100 to 11, then fetch BRANCH at 0x200 (same index 0) -> pred_taken=1.
- REQ-032 Bypass: counter at 01, upd_taken=1 at 0x104 in the same cycle as a BRANCH fetch at 0x104 -> pred_taken=1 next cycle.
- REQ-033 Priority: pred_taken=1 held with enable=0, then flush=1 and enable=0 -> pred_taken=0; a non-branch opcode at a trained-taken PC -> pred_taken=0.
- REQ-034 With BRANCH_PREDICTOR_STATS_EN defined: three updates with (taken,pred) = (1,0), (1,1), (0,1) -> stat_branches=3, stat_mispredicts=2; rst -> both 0.
